// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile: general-purpose register file for the five-stage MIPS pipeline.
//
// 32 x 32-bit registers, two combinational read ports for decode and one
// synchronous write port from write-back. Register 0 is hardwired to zero.
// A same-cycle write-to-read bypass covers the WB->ID hazard that decode's
// EX/MEM forwarding does not.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset; also forces both read ports to 0
//   we      write enable from write-back
//   waddr   write register index
//   wdata   write data
//   re1     read port 1 enable
//   raddr1  read port 1 index
//   rdata1  read port 1 data (combinational)
//   re2     read port 2 enable
//   raddr2  read port 2 index
//   rdata2  read port 2 data (combinational)
// ---------------------------------------------------------------------------
module regfile #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Storage. Writes to index 0 are dropped so regs_q[0] stays zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Shared read-port priority: reset, zero register, bypass, array, disabled.
    function automatic logic [DATA_W-1:0] read_port(input logic              re,
                                                   input logic [ADDR_W-1:0] raddr);
        logic [DATA_W-1:0] data;
        data = '0;
        if (rst) begin
            data = '0;
        end else if (raddr == '0) begin
            data = '0;
        end else if (re && we && (waddr == raddr)) begin
            data = wdata;
        end else if (re) begin
            data = regs_q[raddr];
        end
        return data;
    endfunction

    always_comb begin
        rdata1 = read_port(re1, raddr1);
        rdata2 = read_port(re2, raddr2);
    end

endmodule

// File: tb/tb_regfile.sv
// ---------------------------------------------------------------------------
// tb_regfile: directed self-checking bench for regfile.
// Inputs change 1 time unit after a rising edge; outputs are compared 1 time
// unit later, well before the next edge.
// ---------------------------------------------------------------------------
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    regfile #(
        .DATA_W  (32),
        .ADDR_W  (5),
        .NUM_REGS(32)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re1   (re1),
        .raddr1(raddr1),
        .rdata1(rdata1),
        .re2   (re2),
        .raddr2(raddr2),
        .rdata2(rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs may then be changed.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic [31:0] exp1;
        logic [31:0] exp2;

        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
        tick();
        tick();

        // During reset, bypass condition true: still zero.
        we = 1'b1; waddr = 5'd5; wdata = 32'hA5A5A5A5;
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
        settle();
        check("rst_bypass_p1", rdata1, 32'h0);
        check("rst_bypass_p2", rdata2, 32'h0);
        tick();

        // Out of reset: write during reset was ignored.
        rst = 1'b0; we = 1'b0;
        settle();
        check("post_rst_r5", rdata1, 32'h0);

        // Reset clear test.
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        tick();
        we = 1'b0;
        settle();
        check("r5_written", rdata1, 32'hDEADBEEF);
        rst = 1'b1; we = 1'b1; waddr = 5'd5; wdata = 32'h0BADF00D;
        settle();
        check("rst_forces_zero", rdata1, 32'h0);
        tick();
        rst = 1'b0; we = 1'b0;
        settle();
        check("r5_cleared", rdata1, 32'h0);

        // Write then read on both ports.
        we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
        tick();
        we = 1'b0; re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
        settle();
        check("wr_rd_p1", rdata1, 32'h12345678);
        check("wr_rd_p2", rdata2, 32'h12345678);

        // Bypass.
        we = 1'b1; waddr = 5'd3; wdata = 32'h11111111;
        tick();
        we = 1'b1; waddr = 5'd3; wdata = 32'h22222222; raddr1 = 5'd3; raddr2 = 5'd7;
        settle();
        check("bypass_p1", rdata1, 32'h22222222);
        check("bypass_other_p2", rdata2, 32'h12345678);
        tick();
        we = 1'b0;
        settle();
        check("bypass_committed", rdata1, 32'h22222222);

        // Zero register.
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0;
        settle();
        check("r0_same_cycle", rdata1, 32'h0);
        tick();
        we = 1'b0;
        settle();
        check("r0_next_cycle", rdata1, 32'h0);

        // Read disable.
        we = 1'b1; waddr = 5'd9; wdata = 32'hCAFEF00D;
        tick();
        we = 1'b0; re2 = 1'b0; raddr2 = 5'd9;
        settle();
        check("re2_off", rdata2, 32'h0);
        re2 = 1'b1;
        settle();
        check("re2_on", rdata2, 32'hCAFEF00D);

        // Disabled port ignores a matching bypass.
        we = 1'b1; waddr = 5'd9; wdata = 32'h13579BDF; re2 = 1'b0;
        settle();
        check("re2_off_bypass", rdata2, 32'h0);
        tick();
        we = 1'b0; re2 = 1'b1;
        settle();
        check("re2_after_wr", rdata2, 32'h13579BDF);

        // Back-to-back writes, last wins.
        we = 1'b1; waddr = 5'd10; wdata = 32'h0000AAAA;
        tick();
        wdata = 32'h0000BBBB;
        tick();
        we = 1'b0; raddr1 = 5'd10;
        settle();
        check("b2b_last_wins", rdata1, 32'h0000BBBB);

        // Both ports bypassed in the same cycle.
        we = 1'b1; waddr = 5'd12; wdata = 32'h600DCAFE;
        re1 = 1'b1; raddr1 = 5'd12; re2 = 1'b1; raddr2 = 5'd12;
        settle();
        check("dual_bypass_p1", rdata1, 32'h600DCAFE);
        check("dual_bypass_p2", rdata2, 32'h600DCAFE);
        tick();

        // Sweep: r(i) = i * 0x01010101.
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = 32'(i) * 32'h01010101;
            tick();
        end
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            exp1 = 32'(i) * 32'h01010101;
            exp2 = 32'(31 - i) * 32'h01010101;
            settle();
            check($sformatf("sweep_p1_r%0d", i), rdata1, exp1);
            check($sformatf("sweep_p2_r%0d", 31 - i), rdata2, exp2);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
